pq_cmd_sequencer: RTL and testbench

Command front-end for the BRAM heap priority queue. Accepts push/pop/replace commands on a valid/ready stream, buffers them in a small FIFO and issues them to the queue's `i_wrt`/`i_read`/`i_data` pins. Each issued operation is followed by the settle gap the heap needs before the next command. The block keeps its own occupancy count so illegal operations are rejected before they reach the heap. Popped values are returned on a valid/ready result port.

---
 rtl/pq_pkg.sv | 29 ++
 rtl/pq_cmd_fifo.sv | 54 +++++
 rtl/pq_cmd_sequencer.sv | 133 +++++++++++++
 tb/tb_pq_cmd_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// Shared types and constants for the heap priority queue and its command front-end.
package pq_pkg;

  // Key width shared with the BRAM heap.
  localparam int PQ_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_REPLACE = 2'b11
  } pq_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } seq_state_t;

  // The operation drives the heap's i_wrt pin.
  function automatic logic op_writes(pq_op_t op);
    return (op == OP_PUSH) || (op == OP_REPLACE);
  endfunction

  // The operation drives i_read and returns the old root.
  function automatic logic op_reads(pq_op_t op);
    return (op == OP_POP) || (op == OP_REPLACE);
  endfunction

endpackage

// File: rtl/pq_cmd_fifo.sv
// Small synchronous command FIFO. The head is read straight from the storage
// registers, so an entry written on one edge is visible at the head in the next cycle.
module pq_cmd_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      fill;
  logic             do_wr;
  logic             do_rd;

  assign full  = (fill == (AW+1)'(DEPTH));
  assign empty = (fill == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign head  = mem[rd_ptr];

  // Pointer and fill tracking; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // Entry storage; contents are meaningless while empty, so no reset is needed.
  always_ff @(posedge CLK) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/pq_cmd_sequencer.sv
// Command front-end for the BRAM heap priority queue: buffers push/pop/replace
// commands, rejects illegal ones against a shadow occupancy count, spaces issued
// operations by OP_GAP cycles and returns popped roots on a valid/ready port.
module pq_cmd_sequencer
  import pq_pkg::*;
#(
  parameter int DATA_WIDTH = PQ_DATA_WIDTH,
  parameter int QUEUE_SIZE = 7,
  parameter int FIFO_DEPTH = 4,
  parameter int OP_GAP     = 4
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [1:0]                        s_op,
  input  logic [DATA_WIDTH-1:0]             s_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [DATA_WIDTH-1:0]             m_data,
  output logic                              q_wrt,
  output logic                              q_read,
  output logic [DATA_WIDTH-1:0]             q_data,
  input  logic [DATA_WIDTH-1:0]             q_dout,
  output logic                              err,
  output logic [$clog2(QUEUE_SIZE+1)-1:0]   count
);

  localparam int CNT_W = $clog2(QUEUE_SIZE+1);
  localparam int GAP_W = $clog2(OP_GAP+1);

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_rd;
  logic [DATA_WIDTH+1:0] head;
  pq_op_t                head_op;
  pq_op_t                eff_op;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  reject;
  logic                  stall;
  logic                  issue;
  seq_state_t            state;
  logic [GAP_W-1:0]      gap_cnt;

  // Held low during reset so nothing is accepted into a FIFO that is being cleared.
  assign s_ready = !RST && !fifo_full;

  pq_cmd_fifo #(
    .WIDTH (DATA_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (s_valid && s_ready),
    .wr_data ({s_op, s_data}),
    .full    (fifo_full),
    .rd_en   (fifo_rd),
    .head    (head),
    .empty   (fifo_empty)
  );

  // Head evaluation: legality against the shadow count, result back-pressure, issue decision.
  always_comb begin
    head_op   = pq_op_t'(head[DATA_WIDTH+1:DATA_WIDTH]);
    head_data = head[DATA_WIDTH-1:0];
    eff_op    = head_op;
    if (head_op == OP_REPLACE && count == '0) eff_op = OP_PUSH;
    reject  = ((eff_op == OP_PUSH) && (count == CNT_W'(QUEUE_SIZE))) ||
              ((eff_op == OP_POP)  && (count == '0));
    stall   = op_reads(eff_op) && m_valid && !m_ready;
    fifo_rd = 1'b0;
    issue   = 1'b0;
    if (state == IDLE && !fifo_empty) begin
      if (eff_op == OP_NOP || reject) begin
        fifo_rd = 1'b1;
      end else if (!stall) begin
        fifo_rd = 1'b1;
        issue   = 1'b1;
      end
    end
  end

  // Sequencer FSM with registered heap strobes, shadow count, error pulse and result register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      gap_cnt <= '0;
      count   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      q_wrt   <= 1'b0;
      q_read  <= 1'b0;
      q_data  <= '0;
      err     <= 1'b0;
    end else begin
      q_wrt  <= issue && op_writes(eff_op);
      q_read <= issue && op_reads(eff_op);
      err    <= (state == IDLE) && !fifo_empty && reject;
      if (issue) q_data <= head_data;

      // A fresh capture wins over a consumer handshake on the same edge.
      if (issue && op_reads(eff_op)) begin
        m_data  <= q_dout;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      if (issue) begin
        case (eff_op)
          OP_PUSH: count <= count + 1'b1;
          OP_POP:  count <= count - 1'b1;
          default: count <= count;
        endcase
      end

      case (state)
        IDLE: begin
          if (issue && OP_GAP > 1) begin
            state   <= GAP;
            gap_cnt <= GAP_W'(OP_GAP - 1);
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt == GAP_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pq_cmd_sequencer.sv
// Directed bench for pq_cmd_sequencer: a per-cycle vector table for the basic push
// stream, then hand-written sequences for rejection, back-pressure, burst and reset.
module tb_pq_cmd_sequencer;

  localparam int DW = 16;
  localparam int QS = 7;
  localparam int FD = 4;
  localparam int OG = 4;
  localparam int CW = $clog2(QS+1);

  localparam logic [1:0] NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, REPL = 2'b11;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [1:0]    s_op = 2'b00;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          q_wrt;
  logic          q_read;
  logic [DW-1:0] q_data;
  logic [DW-1:0] q_dout = '0;
  logic          err;
  logic [CW-1:0] count;

  pq_cmd_sequencer #(
    .DATA_WIDTH (DW),
    .QUEUE_SIZE (QS),
    .FIFO_DEPTH (FD),
    .OP_GAP     (OG)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_op    (s_op),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .q_wrt   (q_wrt),
    .q_read  (q_read),
    .q_data  (q_data),
    .q_dout  (q_dout),
    .err     (err),
    .count   (count)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  // Activity monitor on the heap side.
  int            wr_pulses = 0;
  int            rd_pulses = 0;
  int            err_cycles = 0;
  bit            saw_backpressure = 1'b0;
  logic [DW-1:0] wr_log [$];

  always @(negedge CLK) begin
    if (q_wrt) begin
      wr_pulses++;
      wr_log.push_back(q_data);
    end
    if (q_read) rd_pulses++;
    if (err) err_cycles++;
    if (s_valid && !s_ready && !RST) saw_backpressure = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_q_wrt"},   q_wrt,   0);
    chk({tag, "_q_read"},  q_read,  0);
    chk({tag, "_q_data"},  q_data,  0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"},  m_data,  0);
    chk({tag, "_err"},     err,     0);
    chk({tag, "_count"},   count,   0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    s_valid = 1'b0;
    s_op = NOP;
    s_data = '0;
    repeat (3) step();
    check_reset_values("rst");
    RST = 1'b0;
    #1;
    chk("rst_release_s_ready", s_ready, 1);
  endtask

  task automatic send(input logic [1:0] op, input logic [DW-1:0] d);
    int guard;
    guard = 0;
    s_valid = 1'b1;
    s_op = op;
    s_data = d;
    while (!s_ready && guard < 100) begin
      step();
      guard++;
    end
    if (!s_ready) timeout_fail("send");
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_issue(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (q_wrt || q_read) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("wait_issue");
  endtask

  task automatic wait_count(input int target);
    for (int i = 0; i < 100; i++) begin
      if (count == CW'(target)) break;
      step();
    end
    chk("count_reach", count, target);
  endtask

  typedef struct {
    logic          v;
    logic [1:0]    op;
    logic [DW-1:0] d;
    logic          e_ready;
    logic          e_wrt;
    logic          e_read;
    logic [DW-1:0] e_qdata;
    logic          e_err;
    logic [CW-1:0] e_cnt;
    logic          e_mvalid;
  } vec_t;

  function automatic vec_t mk(logic v, logic [1:0] op, logic [DW-1:0] d,
                              logic wrt, logic [DW-1:0] qd, logic [CW-1:0] cnt);
    vec_t r;
    r.v = v; r.op = op; r.d = d;
    r.e_ready = 1'b1; r.e_wrt = wrt; r.e_read = 1'b0; r.e_qdata = qd;
    r.e_err = 1'b0; r.e_cnt = cnt; r.e_mvalid = 1'b0;
    return r;
  endfunction

  vec_t tv [12];

  initial begin
    bit ok;
    int base_wr, base_rd, base_err, base_idx;

    // Push 5, 3, 9 straight after reset: issues land exactly OP_GAP cycles apart.
    tv[0]  = mk(1, PUSH, 5, 0, 0, 0);
    tv[1]  = mk(1, PUSH, 3, 0, 0, 0);
    tv[2]  = mk(1, PUSH, 9, 1, 5, 1);
    tv[3]  = mk(0, NOP,  0, 0, 0, 1);
    tv[4]  = mk(0, NOP,  0, 0, 0, 1);
    tv[5]  = mk(0, NOP,  0, 0, 0, 1);
    tv[6]  = mk(0, NOP,  0, 1, 3, 2);
    tv[7]  = mk(0, NOP,  0, 0, 0, 2);
    tv[8]  = mk(0, NOP,  0, 0, 0, 2);
    tv[9]  = mk(0, NOP,  0, 0, 0, 2);
    tv[10] = mk(0, NOP,  0, 1, 9, 3);
    tv[11] = mk(0, NOP,  0, 0, 0, 3);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("t1[%0d].s_ready", i), s_ready, tv[i].e_ready);
      chk($sformatf("t1[%0d].q_wrt", i),   q_wrt,   tv[i].e_wrt);
      chk($sformatf("t1[%0d].q_read", i),  q_read,  tv[i].e_read);
      chk($sformatf("t1[%0d].err", i),     err,     tv[i].e_err);
      chk($sformatf("t1[%0d].count", i),   count,   tv[i].e_cnt);
      chk($sformatf("t1[%0d].m_valid", i), m_valid, tv[i].e_mvalid);
      if (tv[i].e_wrt) chk($sformatf("t1[%0d].q_data", i), q_data, tv[i].e_qdata);
      s_valid = tv[i].v;
      s_op    = tv[i].op;
      s_data  = tv[i].d;
      step();
    end
    s_valid = 1'b0;

    // Pop on an empty queue is rejected with a one-cycle err; the following push issues.
    do_reset();
    base_err = err_cycles;
    s_valid = 1'b1; s_op = POP; s_data = '0;
    step();
    s_op = PUSH; s_data = 7;
    step();
    s_valid = 1'b0;
    chk("t2_err", err, 1);
    chk("t2_no_read", q_read, 0);
    chk("t2_count0", count, 0);
    step();
    chk("t2_err_off", err, 0);
    chk("t2_push_wrt", q_wrt, 1);
    chk("t2_push_data", q_data, 7);
    chk("t2_count1", count, 1);
    chk("t2_err_len", err_cycles - base_err, 1);

    // Fill to capacity, reject an extra push, then replace at full.
    for (int k = 0; k < 6; k++) send(PUSH, DW'(100 + k));
    wait_count(7);
    base_wr = wr_pulses;
    base_err = err_cycles;
    send(PUSH, 1);
    repeat (10) step();
    chk("t3_full_err_len", err_cycles - base_err, 1);
    chk("t3_full_no_wrt", wr_pulses - base_wr, 0);
    chk("t3_full_count", count, 7);
    q_dout = 10;
    send(REPL, 2);
    wait_issue(ok);
    if (ok) begin
      chk("t3_repl_wrt", q_wrt, 1);
      chk("t3_repl_read", q_read, 1);
      chk("t3_repl_qdata", q_data, 2);
      chk("t3_repl_mvalid", m_valid, 1);
      chk("t3_repl_mdata", m_data, 10);
      chk("t3_repl_count", count, 7);
    end

    // Result back-pressure: a pop stalls while an unconsumed result is held.
    repeat (4) step();
    m_ready = 1'b0;
    q_dout = 20;
    send(POP, 0);
    wait_issue(ok);
    if (ok) begin
      chk("t4_pop1_read", q_read, 1);
      chk("t4_pop1_mdata", m_data, 20);
      chk("t4_pop1_count", count, 6);
    end
    q_dout = 30;
    base_rd = rd_pulses;
    send(POP, 0);
    repeat (12) step();
    chk("t4_stall_no_read", rd_pulses - base_rd, 0);
    chk("t4_stall_count", count, 6);
    chk("t4_stall_mvalid", m_valid, 1);
    chk("t4_stall_mdata", m_data, 20);
    m_ready = 1'b1;
    wait_issue(ok);
    if (ok) begin
      chk("t4_pop2_read", q_read, 1);
      chk("t4_pop2_mvalid", m_valid, 1);
      chk("t4_pop2_mdata", m_data, 30);
      chk("t4_pop2_count", count, 5);
    end

    // Reset during GAP with two commands still buffered.
    repeat (6) step();
    base_wr = wr_pulses;
    send(PUSH, 40);
    send(PUSH, 41);
    send(PUSH, 42);
    chk("t6_first_issue", wr_pulses - base_wr, 1);
    chk("t6_first_data", wr_log[$], 40);
    RST = 1'b1;
    step();
    check_reset_values("t6_rst");
    RST = 1'b0;
    #1;
    chk("t6_release_s_ready", s_ready, 1);
    base_wr = wr_pulses;
    base_rd = rd_pulses;
    repeat (15) step();
    chk("t6_no_wrt", wr_pulses - base_wr, 0);
    chk("t6_no_read", rd_pulses - base_rd, 0);
    chk("t6_count", count, 0);

    // Burst of six pushes into a four-deep FIFO: back-pressure, no loss, no duplication.
    base_idx = wr_log.size();
    saw_backpressure = 1'b0;
    for (int k = 0; k < 6; k++) send(PUSH, DW'(11 + k));
    chk("t5_backpressure", saw_backpressure, 1);
    for (int i = 0; i < 60; i++) begin
      if (wr_log.size() - base_idx >= 6) break;
      step();
    end
    repeat (10) step();
    chk("t5_issue_count", wr_log.size() - base_idx, 6);
    for (int k = 0; k < 6; k++) begin
      if (base_idx + k < wr_log.size())
        chk($sformatf("t5_order[%0d]", k), wr_log[base_idx + k], 11 + k);
      else
        timeout_fail($sformatf("t5_order[%0d]", k));
    end
    chk("t5_count", count, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
